// File: rtl/alif_pkg.sv
// Shared ALIF constants, FSM state type and the single-neuron update datapath.
// Latency: alif_update is purely combinational.
// Backpressure: none; pure function and type definitions.
package alif_pkg;

  localparam logic [7:0] THRESHOLD  = 8'd200;
  localparam logic [7:0] ADAPT_STEP = 8'd40;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] a;
    logic       fire;
  } upd_t;

  // One neuron step. L = vm_leak + a/4 is at most 15 + 63, so 9 bits hold every
  // intermediate value without wrap.
  function automatic upd_t alif_update(input logic [7:0] v,
                                       input logic [7:0] a,
                                       input logic [7:0] c,
                                       input logic [3:0] vm_leak,
                                       input logic [3:0] ad_leak,
                                       input logic [7:0] thr,
                                       input logic [7:0] step);
    upd_t       r;
    logic [8:0] s;
    logic [8:0] l;
    logic [8:0] d;
    r = '0;
    s = '0;
    d = '0;
    l = {5'd0, vm_leak} + {3'd0, a[7:2]};
    if (v >= thr) begin
      r.fire = 1'b1;
      r.v    = 8'd0;
      r.a    = (a < (8'hff - step)) ? (a + step) : 8'hff;
    end else begin
      s = {1'b0, v} + {1'b0, c};
      if (s > l) begin
        d   = s - l;
        r.v = d[8] ? 8'hff : d[7:0];
      end else begin
        r.v = 8'd0;
      end
      r.a = (a > {4'd0, ad_leak}) ? (a - {4'd0, ad_leak}) : 8'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO for spike IDs with registered occupancy count.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: pop only when non-empty; a push into a full FIFO is dropped unless a pop frees a slot that cycle.
//   clk, rst_n      clock, async active-low reset
//   push, push_dat  write request and data
//   pop             read request (ignored when empty)
//   head_dat        entry at the head
//   empty, drop     empty flag; 1 when this cycle's push is being discarded
module spike_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign rd_en    = pop && !empty;
  // A pop in the same cycle frees the slot the full-FIFO push lands in.
  assign wr_en    = push && (!full || rd_en);
  assign drop     = push && !wr_en;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alif_tdm_scheduler.sv
// Time-multiplexed ALIF neuron array: one shared update datapath sweeps all neurons per tick.
// Latency: neuron k written k+1 edges after the tick edge; sweep_done in cycle N+1; spikes reach the FIFO one cycle after firing.
// Backpressure: spike IDs drain over spk_valid/spk_ready; a push into a full FIFO is dropped and counted; ticks while busy are counted and ignored.
//   tick, vm_leak, ad_leak        sweep request and leaks latched with it
//   cfg_we, cfg_addr, cfg_data    input-current write port
//   busy, sweep_done              sweep status
//   spk_valid, spk_id, spk_ready  spike-ID stream
//   mon_sel, mon_vmem, mon_adapt  state monitor
//   drop_cnt, miss_cnt            saturating loss counters
module alif_tdm_scheduler #(
  parameter int         N_NEURONS  = 4,
  parameter logic [7:0] THRESHOLD  = alif_pkg::THRESHOLD,
  parameter logic [7:0] ADAPT_STEP = alif_pkg::ADAPT_STEP,
  parameter int         FIFO_DEPTH = 4,
  localparam int        IDW        = $clog2(N_NEURONS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [3:0]     vm_leak,
  input  logic [3:0]     ad_leak,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_addr,
  input  logic [7:0]     cfg_data,
  output logic           busy,
  output logic           sweep_done,
  output logic           spk_valid,
  output logic [IDW-1:0] spk_id,
  input  logic           spk_ready,
  input  logic [IDW-1:0] mon_sel,
  output logic [7:0]     mon_vmem,
  output logic [7:0]     mon_adapt,
  output logic [7:0]     drop_cnt,
  output logic [7:0]     miss_cnt
);

  import alif_pkg::*;

  logic [7:0]     vmem  [N_NEURONS];
  logic [7:0]     adapt [N_NEURONS];
  logic [7:0]     cur   [N_NEURONS];
  state_t         state;
  logic [IDW-1:0] idx;
  logic [3:0]     vm_leak_q;
  logic [3:0]     ad_leak_q;
  logic           push_vld;
  logic [IDW-1:0] push_dat;
  logic           fifo_empty;
  logic           fifo_drop;
  upd_t           upd;

  assign upd       = alif_update(vmem[idx], adapt[idx], cur[idx], vm_leak_q, ad_leak_q,
                                 THRESHOLD, ADAPT_STEP);
  assign mon_vmem  = vmem[mon_sel];
  assign mon_adapt = adapt[mon_sel];
  assign spk_valid = !fifo_empty;

  // Current writes are independent of the sweep; the datapath reads the pre-edge
  // value, so a write to the neuron being updated takes effect next sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) cur[i] <= '0;
    end else if (cfg_we) begin
      cur[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        vmem[i]  <= '0;
        adapt[i] <= '0;
      end
      state      <= IDLE;
      idx        <= '0;
      vm_leak_q  <= '0;
      ad_leak_q  <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      push_vld   <= 1'b0;
      push_dat   <= '0;
      miss_cnt   <= '0;
    end else begin
      sweep_done <= 1'b0;
      push_vld   <= 1'b0;
      if (tick && (state != IDLE) && (miss_cnt != 8'hff)) miss_cnt <= miss_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            state     <= RUN;
            busy      <= 1'b1;
            idx       <= '0;
            vm_leak_q <= vm_leak;
            ad_leak_q <= ad_leak;
          end
        end
        RUN: begin
          vmem[idx]  <= upd.v;
          adapt[idx] <= upd.a;
          // Spike is registered here and enters the FIFO on the following edge.
          push_vld   <= upd.fire;
          push_dat   <= idx;
          if (idx == IDW'(N_NEURONS - 1)) begin
            state      <= DONE;
            sweep_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (fifo_drop && (drop_cnt != 8'hff)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  spike_fifo #(
    .W     (IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_spike_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (spk_valid && spk_ready),
    .head_dat (spk_id),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

endmodule
